asrm_bus_timer: RTL and testbench

//  Memory-mapped timer that responds on the asrm system bus. The CPU is the initiator; this block is a responder.
//  It provides a prescaled up-counter, a compare match and a pending flag. Its irq output drives one ext_int line of the CPU.
//  The read-data output is zero when the block is not selected, so several responders can be OR-combined onto the CPU data_in.

---
 rtl/asrm_bus_timer_pkg.sv | 18 +
 rtl/asrm_bus_timer_prescaler.sv | 31 +++
 rtl/asrm_bus_timer.sv | 124 ++++++++++++
 tb/tb_asrm_bus_timer.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/asrm_bus_timer_pkg.sv
// Shared definitions for the asrm bus timer: register indices, CTRL bit positions, reset values.
package asrm_bus_timer_pkg;

  typedef enum logic [1:0] {
    TIMER_CTRL  = 2'd0,
    TIMER_PRESC = 2'd1,
    TIMER_COUNT = 2'd2,
    TIMER_CMP   = 2'd3
  } timer_reg_e;

  localparam int unsigned CTRL_EN      = 0;
  localparam int unsigned CTRL_IE      = 1;
  localparam int unsigned CTRL_ONESHOT = 2;
  localparam int unsigned CTRL_PEND    = 7;

  localparam logic TIMER_FLAG_RST = 1'b0;

endpackage

// File: rtl/asrm_bus_timer_prescaler.sv
// Prescaler for the asrm bus timer: psc counts 0..presc while enabled and emits a one-cycle tick on wrap.
module asrm_bus_timer_prescaler #(
  parameter int unsigned wordsize = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                clr,
  input  logic [wordsize-1:0] presc,
  output logic                tick
);

  logic [wordsize-1:0] psc_q, psc_d;

  assign tick = en && (psc_q == presc);

  always_comb begin
    psc_d = psc_q;
    if (clr) begin
      psc_d = '0;
    end else if (en) begin
      psc_d = tick ? '0 : psc_q + wordsize'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) psc_q <= '0;
    else       psc_q <= psc_d;
  end

endmodule

// File: rtl/asrm_bus_timer.sv
// Memory-mapped prescaled timer responder on the asrm bus (CTRL/PRESC/COUNT/CMP, registered read data).
// Define ASRM_TIMER_ONESHOT_EN to implement the CTRL.ONESHOT bit; otherwise the timer is always periodic.
module asrm_bus_timer
  import asrm_bus_timer_pkg::*;
#(
  parameter int unsigned         wordsize  = 16,
  parameter logic [wordsize-1:0] base_addr = 16'hFF00
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [wordsize-1:0] addr,
  input  logic [wordsize-1:0] data_in,
  input  logic                write_en,
  output logic [wordsize-1:0] data_out,
  output logic                irq
);

  localparam int unsigned         BYTES   = wordsize / 8;
  localparam logic [wordsize-1:0] BYTES_W = wordsize'(BYTES);
  localparam logic [wordsize-1:0] SPAN    = wordsize'(4 * BYTES);

  logic [wordsize-1:0] off;
  logic                sel, wr, tick, match;
  timer_reg_e          idx;

  logic                en_q, en_d, ie_q, ie_d, os_q, os_d, pend_q, pend_d;
  logic [wordsize-1:0] presc_q, presc_d, count_q, count_d, cmp_q, cmp_d, rdata_q, rdata_d;

  // Addresses below base wrap to large offsets, so one unsigned compare covers both bounds.
  assign off   = addr - base_addr;
  assign sel   = off < SPAN;
  assign idx   = timer_reg_e'(2'(off / BYTES_W));
  assign wr    = write_en && sel;
  assign match = count_q == cmp_q;

  asrm_bus_timer_prescaler #(.wordsize(wordsize)) u_presc (
    .clk   (clk),
    .reset (reset),
    .en    (en_q),
    .clr   (wr && (idx == TIMER_PRESC)),
    .presc (presc_q),
    .tick  (tick)
  );

  always_comb begin
    en_d    = en_q;
    ie_d    = ie_q;
    os_d    = os_q;
    pend_d  = pend_q;
    presc_d = presc_q;
    count_d = count_q;
    cmp_d   = cmp_q;

    if (tick) begin
      if (match) begin
        count_d = '0;
        pend_d  = 1'b1;
        if (os_q) en_d = 1'b0;
      end else begin
        count_d = count_q + wordsize'(1);
      end
    end

    // Bus writes override tick updates, except that a pending match is never cleared by W1C.
    if (wr) begin
      case (idx)
        TIMER_CTRL: begin
          en_d = data_in[CTRL_EN];
          ie_d = data_in[CTRL_IE];
`ifdef ASRM_TIMER_ONESHOT_EN
          os_d = data_in[CTRL_ONESHOT];
`else
          os_d = 1'b0;
`endif
          if (data_in[CTRL_PEND] && !(tick && match)) pend_d = 1'b0;
        end
        TIMER_PRESC: presc_d = data_in;
        TIMER_COUNT: count_d = data_in;
        TIMER_CMP:   cmp_d   = data_in;
      endcase
    end

    rdata_d = '0;
    if (sel) begin
      case (idx)
        TIMER_CTRL: begin
          rdata_d[CTRL_EN]      = en_q;
          rdata_d[CTRL_IE]      = ie_q;
          rdata_d[CTRL_ONESHOT] = os_q;
          rdata_d[CTRL_PEND]    = pend_q;
        end
        TIMER_PRESC: rdata_d = presc_q;
        TIMER_COUNT: rdata_d = count_q;
        TIMER_CMP:   rdata_d = cmp_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      en_q    <= TIMER_FLAG_RST;
      ie_q    <= TIMER_FLAG_RST;
      os_q    <= TIMER_FLAG_RST;
      pend_q  <= TIMER_FLAG_RST;
      presc_q <= '0;
      count_q <= '0;
      cmp_q   <= '0;
      rdata_q <= '0;
    end else begin
      en_q    <= en_d;
      ie_q    <= ie_d;
      os_q    <= os_d;
      pend_q  <= pend_d;
      presc_q <= presc_d;
      count_q <= count_d;
      cmp_q   <= cmp_d;
      rdata_q <= rdata_d;
    end
  end

  assign data_out = rdata_q;
  assign irq      = pend_q & ie_q;

endmodule

// File: tb/tb_asrm_bus_timer.sv
// Self-checking bench for asrm_bus_timer: reads queue expected data_out, popped one cycle later.
module tb_asrm_bus_timer;

  localparam logic [15:0] BASE = 16'hFF00;

`ifdef ASRM_TIMER_ONESHOT_EN
  localparam bit OS = 1'b1;
`else
  localparam bit OS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] addr, data_in, data_out;
  logic        write_en, irq;

  always #5 clk = ~clk;

  asrm_bus_timer #(.wordsize(16), .base_addr(16'hFF00)) dut (
    .clk      (clk),
    .reset    (reset),
    .addr     (addr),
    .data_in  (data_in),
    .write_en (write_en),
    .data_out (data_out),
    .irq      (irq)
  );

  typedef struct {
    string       tag;
    logic [15:0] exp;
    int          due;
  } sb_t;

  sb_t sb_q[$];
  int  n_chk   = 0;
  int  n_err   = 0;
  int  cyc_cnt = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always @(negedge clk) begin
    sb_t e;
    while (sb_q.size() > 0 && sb_q[0].due <= cyc_cnt) begin
      e = sb_q.pop_front();
      chk(e.tag, data_out, e.exp);
    end
  end

  task automatic cyc(input logic [15:0] a, input logic [15:0] d, input logic we,
                     input bit chk_en, input logic [15:0] exp, input string tag);
    sb_t e;
    addr     = a;
    data_in  = d;
    write_en = we;
    if (chk_en) begin
      e.tag = tag;
      e.exp = exp;
      e.due = cyc_cnt + 1;
      sb_q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic wr(input logic [15:0] off, input logic [15:0] d);
    cyc(BASE + off, d, 1'b1, 1'b0, 16'h0, "");
  endtask

  task automatic rd(input logic [15:0] off, input logic [15:0] exp, input string tag);
    cyc(BASE + off, 16'h0, 1'b0, 1'b1, exp, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; addr = '0; data_in = '0; write_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_dout", data_out, 16'h0);
    chk("rst_irq", {15'h0, irq}, 16'h0);
    reset = 1'b0;

    // reset values of all four registers
    rd(0, 16'h0, "t1_ctrl");
    rd(2, 16'h0, "t1_presc");
    rd(4, 16'h0, "t1_count");
    rd(6, 16'h0, "t1_cmp");
    chk("t1_irq", {15'h0, irq}, 16'h0);

    // PRESC=0 periodic run with interrupt
    wr(6, 16'd3);
    wr(2, 16'd0);
    wr(0, 16'h0003);
    rd(4, 16'd0, "t2_c0");
    rd(4, 16'd1, "t2_c1");
    rd(4, 16'd2, "t2_c2");
    chk("t2_irq_pre", {15'h0, irq}, 16'h0);
    rd(4, 16'd3, "t2_c3");
    chk("t2_irq", {15'h0, irq}, 16'h1);
    rd(4, 16'd0, "t2_wrap");
    rd(0, 16'h0083, "t2_ctrl");
    wr(0, 16'h0083);
    chk("t2_irq_clr", {15'h0, irq}, 16'h0);
    // W1C lands on the same edge as a match: PEND must survive
    wr(0, 16'h0080);
    rd(0, 16'h0080, "t5_pend_kept");
    rd(4, 16'd0, "t5_cnt_held");
    wr(0, 16'h0080);

    // PRESC=2: count every 3 cycles, first match after 6
    wr(6, 16'd1);
    wr(2, 16'd2);
    wr(0, 16'h0001);
    rd(4, 16'd0, "t3_a");
    rd(4, 16'd0, "t3_b");
    rd(4, 16'd0, "t3_c");
    rd(4, 16'd1, "t3_d");
    rd(4, 16'd1, "t3_e");
    rd(4, 16'd1, "t3_f");
    rd(0, 16'h0081, "t3_ctrl");
    chk("t3_irq_masked", {15'h0, irq}, 16'h0);
    wr(0, 16'h0080);

    // wrap from FFFF without a match, bus write vs tick, CTRL write vs tick
    wr(2, 16'd0);
    wr(6, 16'h0010);
    wr(4, 16'hFFFF);
    wr(0, 16'h0001);
    rd(4, 16'hFFFF, "t4_max");
    rd(4, 16'h0000, "t4_wrap");
    rd(0, 16'h0001, "t4_nopend");
    wr(4, 16'd5);
    rd(4, 16'd5, "t5_bus_wins");
    wr(0, 16'h0000);
    rd(4, 16'd7, "t5_ctrl_tick");
    rd(4, 16'd7, "t5_hold");

    // oneshot vs periodic
    wr(4, 16'd0);
    wr(6, 16'd2);
    wr(0, 16'h0005);
    rd(0, OS ? 16'h0005 : 16'h0001, "t6_ctrl");
    rd(4, 16'd1, "t6_c1");
    rd(4, 16'd2, "t6_c2");
    rd(0, OS ? 16'h0084 : 16'h0081, "t6_ctrl_match");
    rd(4, OS ? 16'd0 : 16'd1, "t6_after1");
    rd(4, OS ? 16'd0 : 16'd2, "t6_after2");
    wr(0, 16'h0080);

    // decode boundaries
    cyc(16'h0100, 16'hFFFF, 1'b1, 1'b1, 16'h0, "t8_oor_wr");
    rd(6, 16'd2, "t8_cmp_kept");
    rd(2, 16'd0, "t8_presc_kept");
    rd(0, 16'h0000, "t8_ctrl_kept");
    cyc(16'hFF08, 16'h0, 1'b0, 1'b1, 16'h0, "t8_above");
    cyc(16'hFEFE, 16'h0, 1'b0, 1'b1, 16'h0, "t8_below");
    cyc(16'hFF07, 16'h0, 1'b0, 1'b1, 16'd2, "t8_odd_cmp");

    // reset mid-operation with a simultaneous read
    wr(6, 16'd5);
    wr(0, 16'h0003);
    reset = 1'b1;
    cyc(BASE + 16'd6, 16'h0, 1'b0, 1'b1, 16'h0, "t7_rst_rd");
    reset = 1'b0;
    rd(6, 16'h0, "t7_cmp");
    rd(0, 16'h0, "t7_ctrl");
    rd(4, 16'h0, "t7_count");
    chk("t7_irq", {15'h0, irq}, 16'h0);

    write_en = 1'b0;
    @(negedge clk);
    chk("sb_empty", 16'(sb_q.size()), 16'h0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
